// File: rtl/ps2_dev_rx_fifo.sv
// ps2_dev_rx_fifo: device-side PS/2 host-to-device receiver with a show-ahead frame FIFO.
module ps2_dev_rx_fifo #(
    parameter int DATA_TIMEOUT = 20,
    parameter int PHASE_LEN    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock_quarter,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rx_ready,
    output logic                          rx_valid,
    output logic [7:0]                    rx_data,
    output logic [1:0]                    rx_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          timeout,
    inout  wire                           PS2_CLK,
    inout  wire                           PS2_DAT
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(DATA_TIMEOUT + 2);
    localparam logic [WW-1:0] TO_LIM  = WW'(DATA_TIMEOUT);
    localparam logic [7:0]    PH_LAST = 8'(PHASE_LEN - 1);
    localparam logic [AW:0]   FULL    = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [5:0] {
        IDLE     = 6'b000001,
        WAIT_RTS = 6'b000010,
        DATA     = 6'b000100,
        PARITY   = 6'b001000,
        STOP     = 6'b010000,
        ACK      = 6'b100000
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      clk_sync_q, dat_sync_q;
    logic [WW-1:0]   wait_q, wait_d;
    logic [1:0]      phase_q, phase_d;
    logic [7:0]      len_q, len_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_err_q, par_err_d;
    logic            stop_err_q, stop_err_d;
    logic            timeout_q, timeout_d;
    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q;
    logic            clk_s, dat_s, in_frame, last_len, cell_end, push, pop;

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign in_frame = !(state_q inside {IDLE, WAIT_RTS});
    assign last_len = len_q == PH_LAST;
    assign cell_end = in_frame && phase_q == 2'd3 && last_len;
    assign pop      = rx_valid && rx_ready;

    // Pin drives decode from registered state only, so reset releases them at once.
    assign PS2_CLK = (in_frame && (phase_q == 2'd1 || phase_q == 2'd2)) ? 1'b0 : 1'bz;
    assign PS2_DAT = (state_q == ACK && phase_q != 2'd0 && !stop_err_q) ? 1'b0 : 1'bz;

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        phase_d    = in_frame ? (last_len ? phase_q + 2'd1 : phase_q) : 2'd0;
        len_d      = (in_frame && !last_len) ? len_q + 8'd1 : 8'd0;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        timeout_d  = 1'b0;
        push       = 1'b0;
        case (state_q)
            IDLE: state_d = (enable && count_q != FULL) ? WAIT_RTS : IDLE;
            WAIT_RTS: begin
                wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
                // The first WAIT_RTS cycle still sees the synchronised tail of our own ACK drive.
                if (clk_s && !dat_s && wait_q != '0)
                    state_d = DATA;
                else if (!enable)
                    state_d = IDLE;
                else if (DATA_TIMEOUT != 0 && wait_q > TO_LIM) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            DATA: if (cell_end) begin
                shift_d = {dat_s, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                state_d = (bit_q == 3'd7) ? PARITY : DATA;
            end
            PARITY: if (cell_end) begin
                par_err_d = (^shift_q) == dat_s;
                state_d   = STOP;
            end
            STOP: if (cell_end) begin
                stop_err_d = !dat_s;
                state_d    = ACK;
            end
            ACK: if (cell_end) begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_quarter or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            wait_q     <= '0;
            phase_q    <= '0;
            len_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
            wait_q     <= wait_d;
            phase_q    <= phase_d;
            len_q      <= len_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_ff @(posedge clock_quarter or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) mem_q[wr_q] <= {stop_err_q, par_err_q, shift_q};
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop) count_q <= count_q + 1'b1;
            if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign rx_valid   = count_q != '0;
    assign rx_data    = mem_q[rd_q][7:0];
    assign rx_err     = mem_q[rd_q][9:8];
    assign fifo_count = count_q;
    assign busy       = state_q != IDLE;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_ps2_dev_rx_fifo.sv
// tb_ps2_dev_rx_fifo: host-side PS/2 model driving the receiver, with a scoreboard on the FIFO output.
module tb_ps2_dev_rx_fifo;
    logic       clock_quarter = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       rx_ready = 1'b0;
    logic       host_dat_low = 1'b0;
    logic       rx_valid, busy, timeout;
    logic [7:0] rx_data;
    logic [1:0] rx_err;
    logic [2:0] fifo_count;
    wire        ps2_clk, ps2_dat;
    logic       nt_valid, nt_busy, nt_timeout;
    logic [7:0] nt_data;
    logic [1:0] nt_err;
    logic [2:0] nt_count;
    wire        nt_clk, nt_dat;
    int         checks = 0;
    int         errs = 0;
    int         clk_falls = 0;
    int         nt_pulses = 0;
    logic [9:0] sb[$];

    pullup (ps2_clk);
    pullup (ps2_dat);
    pullup (nt_clk);
    pullup (nt_dat);
    assign ps2_dat = host_dat_low ? 1'b0 : 1'bz;

    always #5 clock_quarter = ~clock_quarter;

    ps2_dev_rx_fifo #(.DATA_TIMEOUT(20), .PHASE_LEN(1), .FIFO_DEPTH(4)) dut (
        .clock_quarter(clock_quarter), .reset(reset), .enable(enable), .rx_ready(rx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err), .fifo_count(fifo_count),
        .busy(busy), .timeout(timeout), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat)
    );

    ps2_dev_rx_fifo #(.DATA_TIMEOUT(0), .PHASE_LEN(1), .FIFO_DEPTH(4)) dut_nt (
        .clock_quarter(clock_quarter), .reset(reset), .enable(1'b1), .rx_ready(1'b0),
        .rx_valid(nt_valid), .rx_data(nt_data), .rx_err(nt_err), .fifo_count(nt_count),
        .busy(nt_busy), .timeout(nt_timeout), .PS2_CLK(nt_clk), .PS2_DAT(nt_dat)
    );

    always @(negedge ps2_clk) clk_falls++;
    always @(posedge clock_quarter) if (nt_timeout) nt_pulses++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk_level(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clock_quarter);
            #1;
            if (ps2_clk === lvl) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        errs++;
        $display("FAIL ps2_clk_wait got no edge expected level %0b", lvl);
    endtask

    // Host changes data just after each falling PS2_CLK; abort_at stops after setting that bit.
    task automatic host_bits(input logic [7:0] b, input logic par, input logic stp,
                             input int abort_at, input bit pop_at_ack);
        bit ok;
        for (int i = 0; i < 11; i++) begin
            wait_clk_level(1'b0, ok);
            if (!ok) begin
                host_dat_low = 1'b0;
                return;
            end
            host_dat_low = (i < 8) ? !b[i] : (i == 8) ? !par : (i == 9) ? !stp : 1'b0;
            if (i == abort_at) return;
            if (i == 10) begin
                #1;
                chk("ack_phase1", 32'(ps2_dat), 32'(!stp));
            end
            wait_clk_level(1'b1, ok);
            if (!ok) return;
            if (i == 10) begin
                chk("ack_phase3", 32'(ps2_dat), 32'(!stp));
                if (pop_at_ack) rx_ready = 1'b1;
                @(posedge clock_quarter);
                #1;
                if (pop_at_ack) rx_ready = 1'b0;
                chk("dat_released", 32'(ps2_dat), 32'd1);
            end
        end
    endtask

    task automatic frame(input logic [7:0] b, input logic par, input logic stp,
                         input logic [1:0] err, input bit pop_at_ack);
        sb.push_back({err, b});
        host_dat_low = 1'b1;
        host_bits(b, par, stp, -1, pop_at_ack);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock_quarter);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int f0;
        logic [7:0] fill [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        logic       fpar [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fork
            forever begin
                @(negedge clock_quarter);
                if (!reset && rx_valid && rx_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL pop_unexpected got %0h expected none", {rx_err, rx_data});
                    end else
                        chk("pop_entry", 32'({rx_err, rx_data}), 32'(sb.pop_front()));
                end
            end
        join_none

        cycles(3);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_err", 32'(rx_err), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_clk", 32'(ps2_clk), 1);
        chk("rst_dat", 32'(ps2_dat), 1);
        reset = 1'b0;
        enable = 1'b1;

        f0 = clk_falls;
        frame(8'hED, 1'b1, 1'b1, 2'b00, 1'b0);
        chk("single_valid", 32'(rx_valid), 1);
        chk("single_count", 32'(fifo_count), 1);
        chk("single_pulses", 32'(clk_falls - f0), 11);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        chk("single_popped", 32'(fifo_count), 0);

        rx_ready = 1'b1;
        frame(8'h55, 1'b0, 1'b1, 2'b01, 1'b0);
        frame(8'h01, 1'b0, 1'b0, 2'b10, 1'b0);
        cycles(3);
        chk("err_drained", 32'(fifo_count), 0);
        rx_ready = 1'b0;

        for (int i = 0; i < 4; i++) frame(fill[i], fpar[i], 1'b1, 2'b00, 1'b0);
        chk("fill_count", 32'(fifo_count), 4);
        sb.push_back({2'b00, fill[4]});
        host_dat_low = 1'b1;
        cycles(40);
        chk("full_busy", 32'(busy), 0);
        chk("full_clk_idle", 32'(ps2_clk), 1);
        chk("full_count", 32'(fifo_count), 4);
        rx_ready = 1'b1;
        cycles(1);
        rx_ready = 1'b0;
        host_bits(fill[4], fpar[4], 1'b1, -1, 1'b0);
        chk("refill_count", 32'(fifo_count), 4);
        rx_ready = 1'b1;
        cycles(8);
        chk("fill_drained", 32'(fifo_count), 0);
        rx_ready = 1'b0;

        frame(8'hA5, 1'b1, 1'b1, 2'b00, 1'b0);
        frame(8'h3C, 1'b1, 1'b1, 2'b00, 1'b0);
        chk("pp_before", 32'(fifo_count), 2);
        frame(8'h7E, 1'b1, 1'b1, 2'b00, 1'b1);
        chk("pp_after", 32'(fifo_count), 2);
        chk("pp_head", 32'({rx_err, rx_data}), 32'({2'b00, 8'h3C}));
        rx_ready = 1'b1;
        cycles(6);
        chk("pp_drained", 32'(fifo_count), 0);
        rx_ready = 1'b0;

        enable = 1'b0;
        cycles(3);
        chk("dis_busy", 32'(busy), 0);
        enable = 1'b1;
        cycles(1);
        chk("arm_busy", 32'(busy), 1);
        k = 0;
        while (!timeout && k < 100) begin
            cycles(1);
            k++;
        end
        chk("timeout_delay", 32'(k), 22);
        chk("timeout_idle", 32'(busy), 0);
        cycles(1);
        chk("timeout_width", 32'(timeout), 0);
        chk("rearm_busy", 32'(busy), 1);
        cycles(5);
        enable = 1'b0;
        cycles(1);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_no_timeout", 32'(timeout), 0);
        enable = 1'b1;

        frame(8'h3C, 1'b1, 1'b1, 2'b00, 1'b0);
        chk("mid_count", 32'(fifo_count), 1);
        host_dat_low = 1'b1;
        host_bits(8'h96, 1'b1, 1'b1, 4, 1'b0);
        chk("mid_clk_low", 32'(ps2_clk), 0);
        reset = 1'b1;
        #1;
        chk("mid_clk_rel", 32'(ps2_clk), 1);
        chk("mid_count_clr", 32'(fifo_count), 0);
        chk("mid_valid_clr", 32'(rx_valid), 0);
        chk("mid_busy_clr", 32'(busy), 0);
        sb.delete();
        host_dat_low = 1'b0;
        #1;
        chk("mid_dat_rel", 32'(ps2_dat), 1);
        cycles(2);
        reset = 1'b0;
        rx_ready = 1'b1;
        frame(8'h96, 1'b1, 1'b1, 2'b00, 1'b0);
        cycles(4);
        chk("post_rst_drained", 32'(fifo_count), 0);
        chk("sb_empty", 32'(sb.size()), 0);

        cycles(1000);
        chk("nt_no_pulse", 32'(nt_pulses), 0);
        chk("nt_waiting", 32'(nt_busy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
